// File: rtl/mem_arbiter.sv
// Two-way arbiter and access sequencer for the MEM-stage data memory port.
// It serves the CPU pipeline and an external loader/debug port, and guards EXT against starvation.
module mem_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int EXT_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  cpu_M,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU_ACC,
        S_EXT_ACC,
        S_CPU_DONE,
        S_EXT_DONE
    } state_e;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);
    localparam logic [3:0] WAIT_MAX = 4'(EXT_MAX_WAIT);

    state_e      state_q, state_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  ext_wait_q, ext_wait_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] ext_rdata_q, ext_rdata_d;

    logic cpu_req;
    logic grant_ext;
    logic unused_m2;

    assign cpu_req   = cpu_M[1] | cpu_M[0];
    assign unused_m2 = cpu_M[2];
    // EXT wins when it is alone, or when it has already lost EXT_MAX_WAIT CPU grants.
    assign grant_ext = ext_req && (!cpu_req || (ext_wait_q == WAIT_MAX));

    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        ext_wait_d  = ext_wait_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_re_d    = mem_re_q;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_ext) begin
                    mem_addr_d  = ext_addr;
                    mem_wdata_d = ext_wdata;
                    mem_we_d    = ext_we;
                    mem_re_d    = !ext_we;
                    lat_cnt_d   = LAT_INIT;
                    ext_wait_d  = 4'd0;
                    state_d     = S_EXT_ACC;
                end else if (cpu_req) begin
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    // Both bits set is a write, never a read.
                    mem_we_d    = cpu_M[1];
                    mem_re_d    = cpu_M[0] & ~cpu_M[1];
                    lat_cnt_d   = LAT_INIT;
                    state_d     = S_CPU_ACC;
                    if (ext_req && (ext_wait_q < WAIT_MAX)) begin
                        ext_wait_d = ext_wait_q + 4'd1;
                    end
                end
            end
            S_CPU_ACC: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    if (mem_re_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                    mem_we_d = 1'b0;
                    mem_re_d = 1'b0;
                    state_d  = S_CPU_DONE;
                end
            end
            S_EXT_ACC: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    if (mem_re_q) begin
                        ext_rdata_d = mem_rdata;
                    end
                    mem_we_d = 1'b0;
                    mem_re_d = 1'b0;
                    state_d  = S_EXT_DONE;
                end
            end
            S_CPU_DONE: state_d = S_IDLE;
            S_EXT_DONE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lat_cnt_q   <= 3'd0;
            ext_wait_q  <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            cpu_rdata_q <= 32'd0;
            ext_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            ext_wait_q  <= ext_wait_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    // Stall drops only in CPU_DONE, so the pipeline advances on the edge that leaves it.
    assign cpu_stall = cpu_req && (state_q != S_CPU_DONE);
    assign ext_ack   = (state_q == S_EXT_DONE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (MEM_LAT 1/3/4), each with its own
// word-addressed memory model, driven by a linear sequence of hand-computed steps.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n     [3];
    logic [2:0]  cpu_M     [3];
    logic [31:0] cpu_addr  [3];
    logic [31:0] cpu_wdata [3];
    logic [31:0] cpu_rdata [3];
    logic        cpu_stall [3];
    logic        ext_req   [3];
    logic        ext_we    [3];
    logic [31:0] ext_addr  [3];
    logic [31:0] ext_wdata [3];
    logic        ext_ack   [3];
    logic [31:0] ext_rdata [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic        mem_we    [3];
    logic        mem_re    [3];
    logic [31:0] mem_rdata [3];

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: MEM_LAT=1, EXT_MAX_WAIT=2; instance 1: MEM_LAT=3; instance 2: MEM_LAT=4.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem_q [256];

        mem_arbiter #(
            .MEM_LAT      (g == 0 ? 1 : (g == 1 ? 3 : 4)),
            .EXT_MAX_WAIT (g == 0 ? 2 : 4)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .cpu_M     (cpu_M[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_stall (cpu_stall[g]),
            .ext_req   (ext_req[g]),
            .ext_we    (ext_we[g]),
            .ext_addr  (ext_addr[g]),
            .ext_wdata (ext_wdata[g]),
            .ext_ack   (ext_ack[g]),
            .ext_rdata (ext_rdata[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_we    (mem_we[g]),
            .mem_re    (mem_re[g]),
            .mem_rdata (mem_rdata[g])
        );

        always @(posedge clk) begin
            if (mem_we[g]) mem_q[mem_addr[g][9:2]] <= mem_wdata[g];
        end
        assign mem_rdata[g] = mem_q[mem_addr[g][9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One CPU access: counts stall cycles and cycles with mem_we/mem_re asserted.
    task automatic cpu_access(input int i, input logic [2:0] m, input logic [31:0] a,
                              input logic [31:0] wd, input int lat, input logic exp_we,
                              input logic [31:0] exp_rd, input string tag);
        int  stall_n, act_n, bad_n;
        bit  done;
        @(posedge clk); #1;
        cpu_M[i] = m; cpu_addr[i] = a; cpu_wdata[i] = wd;
        stall_n = 0; act_n = 0; bad_n = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (mem_we[i] || mem_re[i]) begin
                act_n++;
                if (mem_we[i] !== exp_we || mem_re[i] !== !exp_we || mem_addr[i] !== a ||
                    (exp_we && mem_wdata[i] !== wd)) bad_n++;
            end
            if (cpu_stall[i]) stall_n++;
            else done = 1;
        end
        check({tag, "_done"},  32'(done), 32'd1);
        check({tag, "_stall"}, 32'(stall_n), 32'(lat + 1));
        check({tag, "_act"},   32'(act_n), 32'(lat));
        check({tag, "_ctl"},   32'(bad_n), 32'd0);
        check({tag, "_rdata"}, cpu_rdata[i], exp_rd);
        @(posedge clk); #1;
        cpu_M[i] = 3'b000;
    endtask

    // One EXT access over a fixed 12-cycle window; drop=1 releases ext_req in the first ACC cycle.
    task automatic ext_access(input int i, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input int lat, input logic [31:0] exp_rd,
                              input bit drop, input string tag);
        int first, acks, act_n, bad_n;
        @(posedge clk); #1;
        ext_req[i] = 1'b1; ext_we[i] = we; ext_addr[i] = a; ext_wdata[i] = wd;
        first = -1; acks = 0; act_n = 0; bad_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_we[i] || mem_re[i]) begin
                act_n++;
                if (mem_we[i] !== we || mem_re[i] !== !we || mem_addr[i] !== a ||
                    (we && mem_wdata[i] !== wd)) bad_n++;
            end
            if (ext_ack[i]) begin
                acks++;
                if (first < 0) first = c;
                ext_req[i] = 1'b0;
            end
            if (drop && c == 1) ext_req[i] = 1'b0;
        end
        ext_req[i] = 1'b0;
        check({tag, "_ack_time"},  32'(first), 32'(lat + 1));
        check({tag, "_ack_count"}, 32'(acks), 32'd1);
        check({tag, "_act"},       32'(act_n), 32'(lat));
        check({tag, "_ctl"},       32'(bad_n), 32'd0);
        check({tag, "_rdata"},     ext_rdata[i], exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [5:0]  exp_order;
        logic        got;

        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; cpu_M[i] = 3'b000; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            ext_req[i] = 1'b0; ext_we[i] = 1'b0; ext_addr[i] = '0; ext_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);

        check("rst_mem_we",    32'(mem_we[0]), 32'd0);
        check("rst_mem_re",    32'(mem_re[0]), 32'd0);
        check("rst_mem_addr",  mem_addr[0], 32'd0);
        check("rst_mem_wdata", mem_wdata[0], 32'd0);
        check("rst_ext_ack",   32'(ext_ack[0]), 32'd0);
        check("rst_cpu_rdata", cpu_rdata[0], 32'd0);
        check("rst_ext_rdata", ext_rdata[0], 32'd0);
        check("rst_cpu_stall", 32'(cpu_stall[0]), 32'd0);

        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        idle(2);

        // MEM_LAT=1: preload through EXT, then a CPU load of the same word.
        ext_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0, "ext_wr_10");
        cpu_access(0, 3'b001, 32'h10, 32'h0, 1, 1'b0, 32'hDEADBEEF, "cpu_rd_lat1");

        // EXT write leaves ext_rdata alone; the following read captures the written word.
        ext_access(0, 1'b1, 32'h40, 32'hA5A5A5A5, 1, 32'h0, 1'b0, "ext_wr_40");
        ext_access(0, 1'b0, 32'h40, 32'h0, 1, 32'hA5A5A5A5, 1'b0, "ext_rd_40");

        // Bit 2 of cpu_M is ignored; a CPU read leaves ext_rdata untouched.
        cpu_access(0, 3'b101, 32'h40, 32'h0, 1, 1'b0, 32'hA5A5A5A5, "cpu_rd_m2");
        check("ext_rdata_hold", ext_rdata[0], 32'hA5A5A5A5);
        idle(2);

        // Starvation guard with EXT_MAX_WAIT=2: order CPU,CPU,EXT,CPU,CPU,EXT (bit n = EXT won).
        exp_order = 6'b100100;
        cpu_M[0] = 3'b001; cpu_addr[0] = 32'h100;
        ext_req[0] = 1'b1; ext_we[0] = 1'b0; ext_addr[0] = 32'h200;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (mem_re[0]) begin
                got = (mem_addr[0] === 32'h200);
                check($sformatf("grant_order_%0d", n), 32'(got), 32'(exp_order[n]));
                n++;
            end
        end
        cpu_M[0] = 3'b000;
        ext_req[0] = 1'b0;
        check("grant_count", 32'(n), 32'd6);
        idle(3);

        // MEM_LAT=3: M=011 is a write held for 3 cycles; cpu_rdata stays at its reset value.
        cpu_access(1, 3'b011, 32'h20, 32'h12345678, 3, 1'b1, 32'h0, "cpu_wr_lat3");
        cpu_access(1, 3'b001, 32'h20, 32'h0, 3, 1'b0, 32'h12345678, "cpu_rd_lat3");

        // MEM_LAT=4: reset in the middle of a CPU write.
        @(posedge clk); #1;
        cpu_M[2] = 3'b010; cpu_addr[2] = 32'h30; cpu_wdata[2] = 32'hCAFE0001;
        @(posedge clk); #1;
        @(posedge clk); #3;
        check("pre_rst_mem_we", 32'(mem_we[2]), 32'd1);
        rst_n[2] = 1'b0;
        #1;
        check("mid_rst_mem_we",    32'(mem_we[2]), 32'd0);
        check("mid_rst_mem_re",    32'(mem_re[2]), 32'd0);
        check("mid_rst_mem_addr",  mem_addr[2], 32'd0);
        check("mid_rst_cpu_stall", 32'(cpu_stall[2]), 32'd1);
        check("mid_rst_ext_ack",   32'(ext_ack[2]), 32'd0);
        cpu_M[2] = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst_n[2] = 1'b1;

        cpu_access(2, 3'b010, 32'h30, 32'hCAFE0001, 4, 1'b1, 32'h0, "cpu_wr_after_rst");
        cpu_access(2, 3'b001, 32'h30, 32'h0, 4, 1'b0, 32'hCAFE0001, "cpu_rd_lat4");

        // ext_req dropped one cycle after the grant: one ack, no second access.
        ext_access(2, 1'b0, 32'h30, 32'h0, 4, 32'hCAFE0001, 1'b1, "ext_drop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing controller and two-way arbiter for the MEM-stage data memory. It shares the single dataMemory port between the pipeline's MEM stage (CPU port) and an external loader/debug port (EXT port). It issues registered multi-cycle accesses, stalls the pipeline until a CPU access completes, and runs a req/ack handshake toward EXT with a starvation guard. It sits between the memory stage control (`M` bits, ALU result, store data) and dataMemory.

## Interface
- `MEM_LAT`, default 1: memory access cycles, legal range 1..4; control signals are held for this many cycles.
- `EXT_MAX_WAIT`, default 4: number of CPU grants EXT may lose before it is forced to win (1..15).
- `clk` input, 1 bit: single clock. All state updates on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `cpu_M` input, 3 bits: MEM control. [1]=memwrite, [0]=memread, [2] ignored.
- `cpu_addr` input, 32 bits: ALU result, used as the address.
- `cpu_wdata` input, 32 bits: store data (Dato2).
- `cpu_rdata` output, 32 bits: registered load data.
- `cpu_stall` output, 1 bit: pipeline hold.
- `ext_req` input, 1 bit: EXT request.
- `ext_we` input, 1 bit: EXT write (1) or read (0).
- `ext_addr` input, 32 bits: EXT address.
- `ext_wdata` input, 32 bits: EXT write data.
- `ext_ack` output, 1 bit: one-cycle completion pulse.
- `ext_rdata` output, 32 bits: registered EXT read data.
- `mem_addr` output, 32 bits: to dataMemory addr.
- `mem_wdata` output, 32 bits: to dataMemory write_data.
- `mem_we` output, 1 bit: to memwrite.
- `mem_re` output, 1 bit: to memread.
- `mem_rdata` input, 32 bits: from dataMemory read_data.

## Operation
- CPU request is `cpu_req = cpu_M[1] | cpu_M[0]`. If both bits are set, the access is a write: `mem_we=1`, `mem_re=0`.
- FSM states: IDLE, CPU_ACC, EXT_ACC, CPU_DONE, EXT_DONE.
- IDLE arbitration:
  - Only CPU requesting: grant CPU.
  - Only EXT requesting: grant EXT.
  - Both requesting: grant EXT if `ext_wait == EXT_MAX_WAIT`, otherwise grant CPU.
  - Neither requesting: stay in IDLE.
- On grant:
  - Register the winner's addr, wdata, we and re into the `mem_*` outputs.
  - Load `lat_cnt = MEM_LAT`.
  - Move to the matching _ACC state.
- _ACC states: `mem_*` are held stable and `lat_cnt` decrements each cycle. In the cycle where `lat_cnt == 1`:
  - Sample `mem_rdata` into `cpu_rdata` or `ext_rdata`. Reads only; writes leave the register unchanged.
  - Clear `mem_we` and `mem_re`.
  - Move to the matching _DONE state.
- CPU_DONE → IDLE and EXT_DONE → IDLE, each after one cycle.
- `ext_ack` is 1 only in EXT_DONE. `ext_rdata` holds its value until the next EXT read completes.
- `cpu_stall = cpu_req && (state != CPU_DONE)`. This is combinational, so the pipeline advances exactly on the edge that ends CPU_DONE.
- `ext_wait`, 4 bits:
  - Increments on each CPU grant made while `ext_req=1`.
  - Clears on each EXT grant.
  - Saturates at `EXT_MAX_WAIT`.
- `ext_req` is sampled only in IDLE. Dropping it mid-access does not abort the access; `ext_ack` still pulses. If `ext_req` is still high in the IDLE after EXT_DONE, it is a new request.
- Upstream contract: the CPU and EXT inputs are stable while stalled or awaiting ack.
- Reset (any time, including mid-access):
  - State → IDLE; `lat_cnt`, `ext_wait` → 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `ext_rdata` → 0.
  - `mem_we`, `mem_re`, `ext_ack` → 0.
  - The in-flight access is abandoned with no ack.
  - `cpu_stall` follows `cpu_req`, since the state is IDLE.

## Timing
- CPU access: `cpu_stall` is high for MEM_LAT+1 cycles (the IDLE cycle plus the ACC cycles), then low for the CPU_DONE cycle. The total is MEM_LAT+2 cycles per access.
- EXT access: `ext_ack` rises MEM_LAT+1 cycles after the IDLE cycle that granted it.
- `mem_we`/`mem_re` are registered and asserted for exactly MEM_LAT consecutive cycles per access. There are no glitches and never more than one access in flight.
- Back-to-back CPU accesses: IDLE immediately follows CPU_DONE, giving a minimum spacing of MEM_LAT+2 cycles.
- EXT starvation bound: the wait is at most EXT_MAX_WAIT CPU accesses.

## Test plan
- MEM_LAT=1; `cpu_M=3'b001`, addr=0x10, memory holds 0xDEADBEEF at that address → `mem_re` is high for 1 cycle, `cpu_stall` is high for 2 cycles, and `cpu_rdata=0xDEADBEEF` in CPU_DONE.
- MEM_LAT=3; `cpu_M=3'b011`, addr=0x20, wdata=0x12345678 → `mem_we=1` and `mem_re=0` for 3 cycles. A following read of 0x20 returns 0x12345678.
- EXT write/read with the CPU idle: write 0xA5A5A5A5 to 0x40, then read 0x40 → each `ext_ack` is a 1-cycle pulse, and `ext_rdata=0xA5A5A5A5`.
- EXT_MAX_WAIT=2; `cpu_req` held continuously with `ext_req=1` → grant order is CPU, CPU, EXT, CPU, CPU, EXT; `ext_wait` clears after each EXT grant.
- Assert `rst_n=0` mid-CPU_ACC with MEM_LAT=4 → `mem_we`/`mem_re` drop asynchronously and the state is IDLE. After release, the same request completes normally with a fresh MEM_LAT count.
- Drop `ext_req` one cycle after the EXT grant → the access completes, `ext_ack` pulses once, and no second EXT access follows.
